// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline constants: stage hold bits, stall encodings
// and the stall controller state encoding.
package pipe_ctrl_pkg;

    localparam int XLEN       = 32;
    localparam int NUM_STAGES = 6;

    localparam int STG_PC  = 0;
    localparam int STG_IF  = 1;
    localparam int STG_ID  = 2;
    localparam int STG_EX  = 3;
    localparam int STG_MEM = 4;
    localparam int STG_WB  = 5;

    typedef logic [NUM_STAGES-1:0] stall_vec_t;
    typedef logic [XLEN-1:0]       pc_t;

    localparam stall_vec_t STALL_NONE = 6'b000000;
    localparam stall_vec_t STALL_ID   = 6'b000111;
    localparam stall_vec_t STALL_EX   = 6'b001111;

    localparam pc_t PC_NONE = 32'h0000_0000;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_EX_BUSY = 1'b1
    } ctrl_state_e;

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter used for the stall-cycle performance count.
// Holds at all-ones once reached; cleared by the async reset.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: flush, multi-cycle EX stall and
// load-use stall arbitration with a stall-cycle performance count.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W  = 6,
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stallreq_id,
    input  logic              stallreq_ex,
    input  logic [CNT_W-1:0]  ex_cycles,
    input  logic              flush_req,
    input  logic [31:0]       flush_pc,
    output logic [5:0]        stall_o,
    output logic              flush_o,
    output logic [31:0]       new_pc_o,
    output logic              busy_o,
    output logic [PERF_W-1:0] stall_cnt_o
);

    ctrl_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic ex_start;
    logic ex_active;
    logic stall_any;

    assign ex_start  = (state_q == ST_IDLE) && stallreq_ex;
    assign ex_active = (state_q == ST_EX_BUSY) || ex_start;

    // Output arbitration; everything is forced quiet while in reset.
    always_comb begin
        stall_o  = STALL_NONE;
        flush_o  = 1'b0;
        new_pc_o = PC_NONE;
        busy_o   = 1'b0;
        if (rst) begin
            busy_o = (state_q == ST_EX_BUSY);
            if (flush_req) begin
                flush_o  = 1'b1;
                new_pc_o = flush_pc;
            end else if (ex_active) begin
                stall_o = STALL_EX;
            end else if (stallreq_id) begin
                stall_o = STALL_ID;
            end
        end
    end

    // The start cycle is the first stall cycle, so a length-N request
    // spends N-1 cycles in EX_BUSY; lengths 0 and 1 never leave IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush_req) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (stallreq_ex && (ex_cycles > CNT_W'(1))) begin
                        state_d = ST_EX_BUSY;
                        cnt_d   = ex_cycles - CNT_W'(1);
                    end
                end
                ST_EX_BUSY: begin
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stall_any = (stall_o != STALL_NONE);

    sat_counter #(
        .WIDTH (PERF_W)
    ) u_perf (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_any),
        .count (stall_cnt_o)
    );

endmodule
